// File: rtl/qed_issue_scheduler_pkg.sv
// Shared QED types and constants for the original/duplicate issue scheduler.
// Holds the scheduler state encoding, the instruction width and the default buffer depth.
package qed_issue_scheduler_pkg;

    localparam int unsigned INSTR_W           = 32;
    localparam int unsigned QED_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        PASS = 2'd0,
        ORIG = 2'd1,
        DUP  = 2'd2
    } qed_state_e;

    // Registered issue payload toward the instruction modifier / QED mux
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic               valid;
        logic               select;
    } qed_issue_t;

endpackage

// File: rtl/qed_orig_fifo.sv
// In-order circular buffer of issued originals, replayed later as duplicates.
// Pointers and count are reset; the storage array is not.
module qed_orig_fifo
    import qed_issue_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH  = QED_DEPTH_DEFAULT,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1,
    parameter int unsigned DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/qed_issue_scheduler.sv
// Issues fetched originals, buffers them in ORIG mode and replays them as
// duplicates (qed_select=1) while holding fetch; registered pass-through when QED is off.
module qed_issue_scheduler
    import qed_issue_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = QED_DEPTH_DEFAULT,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               stall,
    input  logic [INSTR_W-1:0] ifu_instruction,
    input  logic               ifu_valid,
    input  logic               sync,
    output logic               ifu_hold,
    output logic [INSTR_W-1:0] qic_qimux_instruction,
    output logic               issue_valid,
    output logic               qed_select,
    output logic [CNT_W-1:0]   qic_count
);

    qed_state_e         state;
    qed_state_e         next_state;
    qed_issue_t         issue_q;
    qed_issue_t         issue_d;
    logic               advance;
    logic               push;
    logic               pop;
    logic [INSTR_W-1:0] pop_data;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_after_push;
    logic               fifo_full;
    logic               fifo_empty;

    qed_orig_fifo #(
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W),
        .DATA_W (INSTR_W)
    ) u_orig_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (ifu_instruction),
        .pop       (pop),
        .pop_data  (pop_data),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign advance          = !stall;
    assign count_after_push = count + CNT_W'(push);

    // Next state, buffer control and next issue word
    always_comb begin
        next_state = state;
        push       = 1'b0;
        pop        = 1'b0;
        issue_d    = issue_q;
        if (advance) begin
            issue_d.valid  = 1'b0;
            issue_d.select = 1'b0;
            case (state)
                PASS: begin
                    if (ifu_valid) begin
                        issue_d.instr = ifu_instruction;
                        issue_d.valid = 1'b1;
                    end
                    if (ena) next_state = ORIG;
                end
                ORIG: begin
                    if (ifu_valid) begin
                        issue_d.instr = ifu_instruction;
                        issue_d.valid = 1'b1;
                        push          = !fifo_full;
                    end
                    if ((count_after_push == CNT_W'(DEPTH)) ||
                        ((count_after_push != '0) && (sync || !ena))) begin
                        next_state = DUP;
                    end else if (!ena) begin
                        next_state = PASS;
                    end
                end
                DUP: begin
                    if (!fifo_empty) begin
                        pop            = 1'b1;
                        issue_d.instr  = pop_data;
                        issue_d.valid  = 1'b1;
                        issue_d.select = 1'b1;
                    end
                    // Drain finishes on the pop that empties the buffer
                    if (count <= CNT_W'(1)) next_state = ena ? ORIG : PASS;
                end
                default: next_state = PASS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PASS;
            issue_q <= '0;
        end else begin
            state   <= next_state;
            issue_q <= issue_d;
        end
    end

    assign ifu_hold              = (state == DUP);
    assign qic_qimux_instruction = issue_q.instr;
    assign issue_valid           = issue_q.valid;
    assign qed_select            = issue_q.select;
    assign qic_count             = count;

endmodule

// File: doc/qed_issue_scheduler.md
# qed_issue_scheduler

Sequences the original/duplicate issue order for QED checking between instruction fetch and the QED instruction mux. It issues fetched originals and records each in an in-order buffer. On a full buffer or a sync request, it stalls fetch and replays the recorded originals on `qic_qimux_instruction`, with `qed_select` high, so the instruction modifier rewrites them into duplicates. With QED disabled it is a registered pass-through.

## Interface
Parameters:
- `DEPTH`, 16: originals buffer depth; power of two, ≥2.
- `CNT_W`, $clog2(DEPTH)+1: width of the occupancy count.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `ena` in 1: QED mode enable.
- `stall` in 1: core pipeline stall. While high, nothing advances and all outputs hold.
- `ifu_instruction` in 32: fetched instruction.
- `ifu_valid` in 1: `ifu_instruction` is valid.
- `sync` in 1: request to drain the buffer as duplicates (checkpoint or end of test).
- `ifu_hold` out 1: fetch must not advance. Combinational: high in state DUP.
- `qic_qimux_instruction` out 32: registered issue word.
- `issue_valid` out 1: registered; the issue word is valid.
- `qed_select` out 1: registered; 1 = the issue word is a buffered original to be issued as a duplicate.
- `qic_count` out CNT_W: current buffer occupancy.

## Operation
- Buffer: circular, DEPTH×32, with read pointer, write pointer and `qic_count`. Pointers wrap modulo DEPTH.
- "Advance" means `stall`==0. "Accept" means advance && `ifu_valid` && state != DUP.
- States:
  - PASS, the reset state.
  - ORIG.
  - DUP.
- PASS:
  - On accept, issue the word with `qed_select`=0 and do not buffer it.
  - On `ena`=1 and advance, go to ORIG.
- ORIG:
  - On accept, issue the word with `qed_select`=0 and push it.
  - Go to DUP on advance when any of these holds:
    - count after this cycle's push == DEPTH;
    - `sync`=1 and count after push > 0;
    - `ena`=0 and count after push > 0.
  - `ena`=0 with count after push == 0: go to PASS.
  - `sync` with an empty buffer: ignored.
- DUP:
  - `ifu_valid` is ignored.
  - On each advance, pop the oldest entry and issue it with `qed_select`=1, `issue_valid`=1.
  - On the pop that empties the buffer (count 1→0): go to ORIG if `ena`=1, else PASS.
  - `ena` and `sync` do not interrupt a drain.
- No advance: outputs are not updated. Next cycle, `issue_valid` keeps its prior value. Re-issue is owned by the core stall logic.
- Advance with nothing to issue (PASS/ORIG with `ifu_valid`=0): `issue_valid`=0, and `qic_qimux_instruction` keeps its last value.
- Duplicates are issued in the exact order of the originals, with the same count.
- `qic_count` never exceeds DEPTH. Push and pop never occur in the same cycle.

## Timing
- Reset values: state=PASS, pointers=0, `qic_count`=0, `qic_qimux_instruction`=32'h0, `issue_valid`=0, `qed_select`=0, `ifu_hold`=0.
- Latency: 1 cycle from accept or pop to the registered issue outputs.
- The transition into DUP takes effect on the clock edge of the triggering cycle. From the next cycle, `ifu_hold`=1, and that cycle's advance issues the first duplicate.
- A drain of N entries takes N advancing cycles. `ifu_hold` falls in the cycle after the last pop.
- Full boundary: the DEPTH-th original is both pushed and issued in its accept cycle. No original is dropped.
- Reset mid-drain: all buffer contents are discarded, the block returns to PASS, and outputs return to their reset values next cycle.

## Structure
- Shared QED package holds:
  - the state enum: PASS=2'd0, ORIG=2'd1, DUP=2'd2;
  - the 32-bit instruction width constant;
  - the default DEPTH.
- One natural sub-module: `qed_orig_fifo`, a synchronous circular buffer with push, pop, count, full and empty; no data reset.
- The scheduler top holds the FSM and the issue registers. `qic_qimux_instruction` and `qed_select` feed the instruction modifier and the final QED issue mux.

## Test plan
- Reset then PASS: `ena`=0; issue 32'h00500093, 32'h00a00113 → the same words appear with `qed_select`=0, 1-cycle latency; `qic_count` stays 0.
- Full trigger: `ena`=1, DEPTH=16, 16 consecutive originals A0..A15 → `ifu_hold` rises after A15. A0..A15 are then replayed with `qed_select`=1 over 16 cycles, `qic_count` 16→0, then the block is back in ORIG.
- Sync trigger: 3 originals, then `sync` pulsed with the third → exactly 3 duplicates in order. A `sync` with an empty buffer produces no duplicates.
- Stall during drain: `stall`=1 for 4 cycles mid-replay → outputs and `qic_count` frozen. The remaining duplicates follow unchanged, none skipped or repeated.
- Disable mid-run: `ena`=0 with 5 entries buffered → a 5-entry drain, then PASS.
- Reset mid-drain: assert `rst` with 7 entries left → next cycle state=PASS, `qic_count`=0, `issue_valid`=0, `ifu_hold`=0.
